// File: rtl/ball_tick_scheduler.sv
// Paces the ball FSM: counts delay phases into a single-cycle done pulse, speeds up on paddle hits, parks the ball after a score.
// Latency: done is registered, one cycle after the last counted delay cycle; serve_hold/speed_level are registered.
// Backpressure: none on the event pulses; a high pause level freezes all counters in place.
//
// Ports:
//   CLK_100MHz  - system clock
//   Reset       - synchronous, active-high reset
//   move        - ball FSM is in its move state (one cycle per step)
//   delay       - ball FSM is in its delay state
//   paddle_hit  - single-cycle pulse, ball hit a paddle
//   score_event - single-cycle pulse, a point was scored
//   pause       - level, freeze all timing while high
//   done        - registered single-cycle pulse ending the ball FSM delay phase
//   serve_hold  - high while the ball is parked for a serve
//   speed_level - current speed level, 0..LVL_MAX
module ball_tick_scheduler #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned BASE_PERIOD = 1_000_000,
    parameter int unsigned STEP        = 100_000,
    parameter int unsigned MIN_PERIOD  = 300_000,
    parameter int unsigned LVL_MAX     = 7,
    parameter int unsigned SERVE_TICKS = 100
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic       move,
    input  logic       delay,
    input  logic       paddle_hit,
    input  logic       score_event,
    input  logic       pause,
    output logic       done,
    output logic       serve_hold,
    output logic [2:0] speed_level
);

    // Period arithmetic gets four guard bits so level*STEP can never wrap.
    localparam int unsigned PW   = CNT_W + 4;
    localparam int unsigned SC_W = (SERVE_TICKS > 2) ? $clog2(SERVE_TICKS) : 1;

    localparam logic [CNT_W-1:0] BASE_LAST  = CNT_W'(BASE_PERIOD - 1);
    localparam logic [CNT_W-1:0] BASE_CNT   = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_PERIOD);
    localparam logic [SC_W-1:0]  SERVE_LAST = SC_W'(SERVE_TICKS - 1);
    localparam logic [PW-1:0]    BASE_W     = PW'(BASE_PERIOD);
    localparam logic [PW-1:0]    STEP_W     = PW'(STEP);
    localparam logic [PW-1:0]    SPAN_W     = PW'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [2:0]       LVL_TOP    = 3'(LVL_MAX);

    typedef enum logic {
        S_SERVE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0]  serve_cnt_q, serve_cnt_d;
    logic [2:0]       level_q, level_d;
    logic [CNT_W-1:0] period_lat_q, period_lat_d;
    logic             done_q, done_d;
    logic             serve_hold_q, serve_hold_d;

    logic [PW-1:0]    lvl_step;
    logic [CNT_W-1:0] period;

    // Step period for the current level, floored at MIN_PERIOD.
    assign lvl_step = PW'(level_q) * STEP_W;
    assign period   = (lvl_step >= SPAN_W) ? MIN_CNT : CNT_W'(BASE_W - lvl_step);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        serve_cnt_d  = serve_cnt_q;
        level_d      = level_q;
        period_lat_d = period_lat_q;
        done_d       = 1'b0;

        if (score_event) begin
            state_d     = S_SERVE;
            level_d     = '0;
            cnt_d       = '0;
            serve_cnt_d = '0;
        end else begin
            case (state_q)
                S_SERVE: begin
                    if (!pause) begin
                        if (cnt_q == BASE_LAST) begin
                            cnt_d = '0;
                            if (serve_cnt_q == SERVE_LAST) begin
                                state_d     = S_RUN;
                                serve_cnt_d = '0;
                            end else begin
                                serve_cnt_d = serve_cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Latch at move so a hit mid-delay only affects the next phase.
                    if (move) begin
                        period_lat_d = period;
                    end
                    if (!pause) begin
                        if (paddle_hit && (level_q < LVL_TOP)) begin
                            level_d = level_q + 1'b1;
                        end
                        if (!delay) begin
                            cnt_d = '0;
                        end else if (!done_q) begin
                            // Counting stalls while done is out, so pulses never merge.
                            if (cnt_q == (period_lat_q - CNT_W'(1))) begin
                                done_d = 1'b1;
                                cnt_d  = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_SERVE;
            endcase
        end

        serve_hold_d = (state_d == S_SERVE);
    end

    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            state_q      <= S_SERVE;
            cnt_q        <= '0;
            serve_cnt_q  <= '0;
            level_q      <= '0;
            period_lat_q <= BASE_CNT;
            done_q       <= 1'b0;
            serve_hold_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            serve_cnt_q  <= serve_cnt_d;
            level_q      <= level_d;
            period_lat_q <= period_lat_d;
            done_q       <= done_d;
            serve_hold_q <= serve_hold_d;
        end
    end

    assign done        = done_q;
    assign serve_hold  = serve_hold_q;
    assign speed_level = level_q;

endmodule

// File: tb/tb_ball_tick_scheduler.sv
// Bench for ball_tick_scheduler with a registered model of the ball FSM attached.
// Expected delay-phase lengths, done spacing, levels and serve lengths are queued by the stimulus;
// a negedge monitor measures each done pulse and each serve interval and compares against the queues.
module tb_ball_tick_scheduler;

    logic       CLK_100MHz  = 1'b0;
    logic       Reset       = 1'b1;
    logic       paddle_hit  = 1'b0;
    logic       score_event = 1'b0;
    logic       pause       = 1'b0;
    logic       move;
    logic       delay;
    logic       done;
    logic       serve_hold;
    logic [2:0] speed_level;

    ball_tick_scheduler #(
        .CNT_W      (24),
        .BASE_PERIOD(10),
        .STEP       (2),
        .MIN_PERIOD (4),
        .LVL_MAX    (7),
        .SERVE_TICKS(2)
    ) dut (
        .CLK_100MHz (CLK_100MHz),
        .Reset      (Reset),
        .move       (move),
        .delay      (delay),
        .paddle_hit (paddle_hit),
        .score_event(score_event),
        .pause      (pause),
        .done       (done),
        .serve_hold (serve_hold),
        .speed_level(speed_level)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    // Ball FSM model: move (1 cycle) -> delay (until done) -> check (1 cycle) -> move ...
    typedef enum logic [1:0] {F_IDLE, F_MOVE, F_DELAY, F_CHECK} fsm_t;
    fsm_t fst = F_IDLE;

    always @(posedge CLK_100MHz) begin
        if (Reset || serve_hold) begin
            fst <= F_IDLE;
        end else begin
            case (fst)
                F_IDLE:  fst <= F_MOVE;
                F_MOVE:  fst <= F_DELAY;
                F_DELAY: if (done) fst <= F_CHECK;
                default: fst <= F_MOVE;
            endcase
        end
    end

    assign move  = (fst == F_MOVE);
    assign delay = (fst == F_DELAY);

    // Scoreboard
    typedef struct {
        int dlen;   // cycles with delay high, including the done cycle
        int gap;    // cycles since previous done, -1 = not checked
        int lvl;    // speed_level while done is high
    } done_exp_t;

    done_exp_t dq[$];
    int        sq[$];
    int        checks    = 0;
    int        passed    = 0;
    int        done_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor
    int        cyc       = 0;
    int        dcnt      = 0;
    int        scnt      = 0;
    int        last_done = 0;
    logic      prev_done = 1'b0;
    done_exp_t cur;
    int        sexp;

    always @(negedge CLK_100MHz) begin
        cyc++;
        if (Reset) begin
            dcnt      = 0;
            scnt      = 0;
            prev_done = 1'b0;
        end else begin
            if (delay) dcnt++;
            else dcnt = 0;
            if (done) begin
                done_seen++;
                chk("done_width", int'(prev_done), 0);
                if (dq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
                end else begin
                    cur = dq.pop_front();
                    chk("delay_len", dcnt, cur.dlen);
                    if (cur.gap >= 0) chk("done_gap", cyc - last_done, cur.gap);
                    chk("done_level", int'(speed_level), cur.lvl);
                end
                last_done = cyc;
            end
            prev_done = done;
            if (serve_hold) begin
                scnt++;
            end else if (scnt > 0) begin
                if (sq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_serve: length %0d, expected none", scnt);
                end else begin
                    sexp = sq.pop_front();
                    chk("serve_len", scnt, sexp);
                end
                scnt = 0;
            end
        end
    end

    // Stimulus helpers
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_100MHz);
            #1;
        end
    endtask

    task automatic wait_dones_to(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done_seen >= target) break;
            tick(1);
        end
        if (done_seen < target) begin
            checks++;
            $display("FAIL timeout_%s: saw %0d dones, expected %0d", tag, done_seen, target);
        end
    endtask

    task automatic wait_move(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (move) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL timeout_move_%s: move got 0, expected 1", tag);
        end
    endtask

    task automatic push_done(input int dlen, input int gap, input int lvl);
        done_exp_t e;
        e.dlen = dlen;
        e.gap  = gap;
        e.lvl  = lvl;
        dq.push_back(e);
    endtask

    initial begin
        int base;

        // Reset state
        tick(3);
        chk("reset_done", int'(done), 0);
        chk("reset_serve_hold", int'(serve_hold), 1);
        chk("reset_level", int'(speed_level), 0);

        // Serve after reset, then level-0 steps
        base = done_seen;
        sq.push_back(20);
        push_done(11, -1, 0);
        push_done(11, 13, 0);
        push_done(11, 13, 0);
        Reset = 1'b0;
        wait_dones_to(base + 3, 300, "level0");

        // Two hits mid-delay: current phase unchanged, following phases period 6
        base = done_seen;
        push_done(11, 13, 2);
        push_done(7, 9, 2);
        push_done(7, 9, 2);
        wait_move(50, "hits2");
        tick(2);
        paddle_hit = 1'b1; tick(1); paddle_hit = 1'b0; tick(1);
        paddle_hit = 1'b1; tick(1); paddle_hit = 1'b0;
        wait_dones_to(base + 3, 300, "hits2");

        // Nine hits: level saturates at 7, period floors at 4
        base = done_seen;
        push_done(7, 9, 7);
        push_done(5, 7, 7);
        push_done(5, 7, 7);
        wait_move(50, "hits9");
        paddle_hit = 1'b1;
        tick(9);
        paddle_hit = 1'b0;
        wait_dones_to(base + 3, 300, "hits9");

        // Score with simultaneous hit, on the cycle a done would be issued
        base = done_seen;
        sq.push_back(70);
        wait_move(50, "score");
        tick(4);
        score_event = 1'b1;
        paddle_hit  = 1'b1;
        tick(1);
        score_event = 1'b0;
        paddle_hit  = 1'b0;
        chk("score_done", int'(done), 0);
        chk("score_serve_hold", int'(serve_hold), 1);
        chk("score_level", int'(speed_level), 0);
        // Pause during the serve stretches it by 50 cycles
        tick(3);
        pause = 1'b1;
        tick(50);
        pause = 1'b0;
        push_done(11, -1, 0);
        wait_dones_to(base + 1, 300, "serve_pause");

        // Pause for 50 cycles with cnt at 6
        base = done_seen;
        push_done(61, 63, 0);
        push_done(11, 13, 0);
        wait_move(50, "run_pause");
        tick(7);
        pause = 1'b1;
        tick(50);
        pause = 1'b0;
        wait_dones_to(base + 2, 300, "run_pause");

        // Reset in the middle of a serve restarts a full serve
        base = done_seen;
        sq.push_back(20);
        push_done(11, -1, 0);
        score_event = 1'b1;
        tick(1);
        score_event = 1'b0;
        tick(8);
        Reset = 1'b1;
        tick(2);
        chk("midreset_done", int'(done), 0);
        chk("midreset_serve_hold", int'(serve_hold), 1);
        chk("midreset_level", int'(speed_level), 0);
        Reset = 1'b0;
        wait_dones_to(base + 1, 300, "midreset");

        tick(2);
        chk("done_queue_left", dq.size(), 0);
        chk("serve_queue_left", sq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks", passed, checks);
        $fatal(1);
    end

endmodule
